// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared encodings and defaults for the unified-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Default geometry: 8 x 16-bit words per 16-byte line, 16-bit byte address.
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_ADDR_W     = 16;
  localparam int DATA_W         = 16;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  // Which cache owns the line currently being filled.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // True while a line fill holds the memory (issuing or waiting on returns).
  function automatic logic in_line_fill(input arb_state_t s);
    return (s == ST_FILL) || (s == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Request, memory and fill-steering signals around the arbiter.
//            slave  = the arbiter itself, master = caches plus memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              ifill_req;
  logic [ADDR_W-1:0] ifill_addr;
  logic              dfill_req;
  logic [ADDR_W-1:0] dfill_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_data_valid;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              i_data_we;
  logic              d_data_we;
  logic              i_tag_we;
  logic              d_tag_we;
  logic              i_busy;
  logic              d_busy;
  logic              wr_ack;

  modport slave (
    input  ifill_req, ifill_addr, dfill_req, dfill_addr,
    input  wr_req, wr_addr, wr_data, mem_data_out, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_data_in, fill_addr, fill_data,
    output i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy, wr_ack
  );

  modport master (
    output ifill_req, ifill_addr, dfill_req, dfill_addr,
    output wr_req, wr_addr, wr_data, mem_data_out, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_data_in, fill_addr, fill_data,
    input  i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy, wr_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_line_word_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : line_word_counter
// Brief    : Word index within a cache line; sync clear, enable, and a
//            terminal-count flag on the last word of the line.
// Revision : 1.0 - initial release
// ============================================================================
module line_word_counter #(
  parameter int LINE_WORDS = 8
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          i_clr,
  input  wire logic                          i_en,
  output logic [$clog2(LINE_WORDS)-1:0]      o_cnt,
  output logic                               o_tc
);
  localparam int C_CNT_W = $clog2(LINE_WORDS);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(LINE_WORDS - 1);

  logic [C_CNT_W-1:0] r_cnt;

  // Clear wins over enable so a new line always starts at word 0.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares the pipelined unified memory between I-cache fills,
//            D-cache fills and D-side write-through. Issues the word reads
//            of a line back to back, steers returning words into the owning
//            cache and pulses its tag write on the last word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_arbiter_if.slave    bus
);
  localparam int C_OFFSET_BITS = $clog2(LINE_WORDS);
  // Line base = byte address with word offset and byte-in-word bit removed.
  localparam int C_LINE_BITS   = ADDR_W - C_OFFSET_BITS - 1;

  arb_state_t               r_state;
  arb_state_t               w_state_next;
  owner_t                   r_owner;
  owner_t                   w_grant_owner;
  logic [C_LINE_BITS-1:0]   r_line_base;
  logic [C_LINE_BITS-1:0]   w_grant_base;
  logic                     w_grant;

  logic [C_OFFSET_BITS-1:0] w_issue_cnt;
  logic                     w_issue_tc;
  logic [C_OFFSET_BITS-1:0] w_ret_cnt;
  logic                     w_ret_tc;

  logic                     w_in_line;
  logic                     w_issue;
  logic                     w_ret;
  logic                     w_last_ret;

  logic                     w_mem_en;
  logic                     w_mem_wr;
  logic [ADDR_W-1:0]        w_mem_addr;
  logic [DATA_W-1:0]        w_mem_data_in;
  logic [ADDR_W-1:0]        w_fill_addr;
  logic                     w_i_data_we;
  logic                     w_d_data_we;
  logic                     w_i_tag_we;
  logic                     w_d_tag_we;
  logic                     w_wr_ack;

  // Returns only count while a fill owns the memory; stray valids elsewhere
  // (including stragglers from a fill aborted by reset) are dropped here.
  assign w_in_line  = in_line_fill(r_state);
  assign w_issue    = (r_state == ST_FILL);
  assign w_ret      = bus.mem_data_valid && w_in_line;
  assign w_last_ret = w_ret && w_ret_tc;

  line_word_counter #(
    .LINE_WORDS (LINE_WORDS)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_in_line),
    .i_en  (w_issue),
    .o_cnt (w_issue_cnt),
    .o_tc  (w_issue_tc)
  );

  line_word_counter #(
    .LINE_WORDS (LINE_WORDS)
  ) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_in_line),
    .i_en  (w_ret),
    .o_cnt (w_ret_cnt),
    .o_tc  (w_ret_tc)
  );

  // State, owner and line base; owner/base are captured only at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_line_base <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner     <= w_grant_owner;
        r_line_base <= w_grant_base;
      end
    end
  end

  // Next state and grant selection. D miss outranks the write so that a
  // write-miss line is filled before the write-through goes out.
  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_grant_owner = OWN_NONE;
    w_grant_base  = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.dfill_req) begin
          w_state_next  = ST_FILL;
          w_grant       = 1'b1;
          w_grant_owner = OWN_D;
          w_grant_base  = bus.dfill_addr[ADDR_W-1 -: C_LINE_BITS];
        end else if (bus.wr_req) begin
          w_state_next  = ST_WRITE;
          w_grant       = 1'b1;
          w_grant_owner = OWN_NONE;
          w_grant_base  = bus.wr_addr[ADDR_W-1 -: C_LINE_BITS];
        end else if (bus.ifill_req) begin
          w_state_next  = ST_FILL;
          w_grant       = 1'b1;
          w_grant_owner = OWN_I;
          w_grant_base  = bus.ifill_addr[ADDR_W-1 -: C_LINE_BITS];
        end
      end
      ST_WRITE: w_state_next = ST_IDLE;
      ST_FILL: begin
        if (w_last_ret) begin
          w_state_next = ST_DONE;
        end else if (w_issue_tc) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_ret) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Memory command and fill-steering outputs; everything idles at zero.
  always_comb begin
    w_mem_en      = 1'b0;
    w_mem_wr      = 1'b0;
    w_mem_addr    = '0;
    w_mem_data_in = '0;
    w_wr_ack      = 1'b0;
    w_fill_addr   = '0;
    w_i_data_we   = 1'b0;
    w_d_data_we   = 1'b0;
    w_i_tag_we    = 1'b0;
    w_d_tag_we    = 1'b0;
    if (r_state == ST_WRITE) begin
      w_mem_en      = 1'b1;
      w_mem_wr      = 1'b1;
      w_mem_addr    = bus.wr_addr;
      w_mem_data_in = bus.wr_data;
      w_wr_ack      = 1'b1;
    end else if (w_issue) begin
      w_mem_en   = 1'b1;
      w_mem_addr = {r_line_base, w_issue_cnt, 1'b0};
    end
    if (w_ret) begin
      w_fill_addr = {r_line_base, w_ret_cnt, 1'b0};
      w_i_data_we = (r_owner == OWN_I);
      w_d_data_we = (r_owner == OWN_D);
      w_i_tag_we  = w_ret_tc && (r_owner == OWN_I);
      w_d_tag_we  = w_ret_tc && (r_owner == OWN_D);
    end
  end

  assign bus.mem_en      = w_mem_en;
  assign bus.mem_wr      = w_mem_wr;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_data_in = w_mem_data_in;
  assign bus.wr_ack      = w_wr_ack;
  assign bus.fill_addr   = w_fill_addr;
  assign bus.fill_data   = bus.mem_data_out;
  assign bus.i_data_we   = w_i_data_we;
  assign bus.d_data_we   = w_d_data_we;
  assign bus.i_tag_we    = w_i_tag_we;
  assign bus.d_tag_we    = w_d_tag_we;
  assign bus.i_busy      = w_in_line && (r_owner == OWN_I);
  assign bus.d_busy      = w_in_line && (r_owner == OWN_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a 4-cycle pipelined
//            memory model and a line-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16)) bus ();

  mem_arbiter #(
    .LINE_WORDS (8),
    .ADDR_W     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  busy;   // {i_busy, d_busy}
    bit          first;
    int          op;
  } cmd_t;

  typedef struct {
    bit          is_d;
    logic [15:0] addr;
    logic [15:0] data;
    bit          tag;
  } fill_t;

  cmd_t  cmd_q[$];
  fill_t fill_q[$];

  logic [15:0] phys_mem [0:32767];
  logic [15:0] ref_mem  [0:32767];

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;

  // Monitor-owned bookkeeping.
  int cyc = 0, ops_done = 0, next_ok_cyc = 0, last_rd_cyc = 0;
  int i_tag_cnt = 0, d_tag_cnt = 0, wr_ack_cnt = 0;

  // Memory model pipeline and spurious-valid injection.
  bit          pipe_v [LAT];
  logic [15:0] pipe_d [LAT];
  bit          inject_valid = 1'b0;
  logic [15:0] inject_data  = '0;

  assign bus.mem_data_valid = pipe_v[LAT-1] | inject_valid;
  assign bus.mem_data_out   = inject_valid ? inject_data : pipe_d[LAT-1];

  // Pipelined memory: command sampled mid-cycle, data visible LAT cycles later.
  initial begin
    bit cap_en, cap_wr;
    logic [15:0] cap_a, cap_d;
    for (int s = 0; s < LAT; s++) begin
      pipe_v[s] = 1'b0;
      pipe_d[s] = '0;
    end
    forever begin
      @(negedge clk);
      cap_en = bus.mem_en; cap_wr = bus.mem_wr;
      cap_a  = bus.mem_addr; cap_d = bus.mem_data_in;
      @(posedge clk);
      #1;
      if (cap_en && cap_wr) phys_mem[cap_a[15:1]] = cap_d;
      for (int s = LAT-1; s > 0; s--) begin
        pipe_v[s] = pipe_v[s-1];
        pipe_d[s] = pipe_d[s-1];
      end
      pipe_v[0] = cap_en && !cap_wr;
      pipe_d[0] = (cap_en && !cap_wr) ? phys_mem[cap_a[15:1]] : 16'h0;
    end
  end

  // Scoreboard monitor: pops an expectation whenever the DUT presents a
  // memory command or a cache write.
  initial begin
    cmd_t  c;
    fill_t f;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_en) begin
        if (bus.mem_en) begin
          n_checks++;
          if (cmd_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_mem_cmd: wr=%0b addr=%h at cycle %0d, required no command",
                     bus.mem_wr, bus.mem_addr, cyc);
          end else begin
            c = cmd_q.pop_front();
            if (bus.mem_wr !== c.wr || bus.wr_ack !== c.wr || bus.mem_addr !== c.addr ||
                (c.wr && bus.mem_data_in !== c.data) || {bus.i_busy, bus.d_busy} !== c.busy) begin
              n_fail++;
              $display("FAIL mem_cmd: got wr=%0b ack=%0b addr=%h data=%h busy=%b, required wr=%0b addr=%h data=%h busy=%b",
                       bus.mem_wr, bus.wr_ack, bus.mem_addr, bus.mem_data_in, {bus.i_busy, bus.d_busy},
                       c.wr, c.addr, c.data, c.busy);
            end
            n_checks++;
            if (c.first) begin
              if (ops_done != c.op || cyc < next_ok_cyc) begin
                n_fail++;
                $display("FAIL op_order: op %0d started cycle %0d with %0d ops done, required %0d done and cycle >= %0d",
                         c.op, cyc, ops_done, c.op, next_ok_cyc);
              end
            end else if (cyc != last_rd_cyc + 1) begin
              n_fail++;
              $display("FAIL issue_gap: read %h at cycle %0d, required cycle %0d",
                       c.addr, cyc, last_rd_cyc + 1);
            end
            last_rd_cyc = cyc;
          end
        end else begin
          n_checks++;
          if (bus.mem_wr || bus.wr_ack || bus.mem_addr != 0 || bus.mem_data_in != 0) begin
            n_fail++;
            $display("FAIL idle_mem: wr=%0b ack=%0b addr=%h data=%h, required all 0",
                     bus.mem_wr, bus.wr_ack, bus.mem_addr, bus.mem_data_in);
          end
        end

        if (bus.i_data_we || bus.d_data_we) begin
          n_checks++;
          if (fill_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_fill: i_we=%0b d_we=%0b addr=%h, required no write",
                     bus.i_data_we, bus.d_data_we, bus.fill_addr);
          end else begin
            f = fill_q.pop_front();
            if ({bus.i_data_we, bus.d_data_we, bus.i_tag_we, bus.d_tag_we} !==
                {!f.is_d, f.is_d, !f.is_d && f.tag, f.is_d && f.tag} ||
                bus.fill_addr !== f.addr || bus.fill_data !== f.data) begin
              n_fail++;
              $display("FAIL fill_word: got we(i,d)=%0b%0b tag(i,d)=%0b%0b addr=%h data=%h, required we=%0b%0b tag=%0b%0b addr=%h data=%h",
                       bus.i_data_we, bus.d_data_we, bus.i_tag_we, bus.d_tag_we, bus.fill_addr, bus.fill_data,
                       !f.is_d, f.is_d, !f.is_d && f.tag, f.is_d && f.tag, f.addr, f.data);
            end
          end
        end else begin
          n_checks++;
          if (bus.i_tag_we || bus.d_tag_we || bus.fill_addr != 0) begin
            n_fail++;
            $display("FAIL tag_without_data: tag(i,d)=%0b%0b fill_addr=%h, required 0",
                     bus.i_tag_we, bus.d_tag_we, bus.fill_addr);
          end
        end

        if (bus.i_tag_we || bus.d_tag_we || bus.wr_ack) begin
          ops_done++;
          // A fill is followed by DONE then IDLE; a write goes straight to IDLE.
          next_ok_cyc = cyc + (bus.wr_ack ? 2 : 3);
        end
      end
      if (bus.i_tag_we) i_tag_cnt++;
      if (bus.d_tag_we) d_tag_cnt++;
      if (bus.wr_ack)   wr_ack_cnt++;
    end
  end

  // Reference model: one line fill = 8 reads of consecutive words from the
  // line base, answered in order from the current memory image.
  task automatic model_fill(input bit is_d, input logic [15:0] a, input int op);
    logic [15:0] base, wa;
    cmd_t  c;
    fill_t f;
    base = a & 16'hFFF0;
    for (int j = 0; j < 8; j++) begin
      wa = base + 16'(2 * j);
      c.wr = 1'b0; c.addr = wa; c.data = 16'h0;
      c.busy = is_d ? 2'b01 : 2'b10; c.first = (j == 0); c.op = op;
      cmd_q.push_back(c);
      f.is_d = is_d; f.addr = wa; f.data = ref_mem[wa[15:1]]; f.tag = (j == 7);
      fill_q.push_back(f);
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input int op);
    cmd_t c;
    c.wr = 1'b1; c.addr = a; c.data = d; c.busy = 2'b00; c.first = 1'b1; c.op = op;
    cmd_q.push_back(c);
    ref_mem[a[15:1]] = d;
  endtask

  // Raise a set of requests together; service order is D fill, write, I fill.
  task automatic run_ops(input bit do_d, input bit do_w, input bit do_i,
                         input logic [15:0] d_a, input logic [15:0] w_a,
                         input logic [15:0] w_d, input logic [15:0] i_a);
    int base, k, ib, db, wb;
    @(posedge clk);
    #1;
    base = ops_done; k = 0;
    ib = i_tag_cnt; db = d_tag_cnt; wb = wr_ack_cnt;
    if (do_d) begin model_fill(1'b1, d_a, base + k); k++; end
    if (do_w) begin model_write(w_a, w_d, base + k); k++; end
    if (do_i) begin model_fill(1'b0, i_a, base + k); k++; end
    bus.dfill_addr = d_a; bus.wr_addr = w_a; bus.wr_data = w_d; bus.ifill_addr = i_a;
    bus.dfill_req = do_d; bus.wr_req = do_w; bus.ifill_req = do_i;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #1;
      if (bus.dfill_req && d_tag_cnt != db) bus.dfill_req = 1'b0;
      if (bus.wr_req && wr_ack_cnt != wb)   bus.wr_req    = 1'b0;
      if (bus.ifill_req && i_tag_cnt != ib) bus.ifill_req = 1'b0;
      if (!bus.dfill_req && !bus.wr_req && !bus.ifill_req) break;
    end
    n_checks++;
    if (bus.dfill_req || bus.wr_req || bus.ifill_req) begin
      n_fail++;
      $display("FAIL op_timeout: reqs still pending d=%0b w=%0b i=%0b, required all served",
               bus.dfill_req, bus.wr_req, bus.ifill_req);
      bus.dfill_req = 1'b0; bus.wr_req = 1'b0; bus.ifill_req = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_q.size() != 0 || fill_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d commands and %0d fills outstanding, required 0",
               cmd_q.size(), fill_q.size());
      cmd_q.delete(); fill_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.fill_addr,
         bus.i_data_we, bus.d_data_we, bus.i_tag_we, bus.d_tag_we,
         bus.i_busy, bus.d_busy, bus.wr_ack} != '0) begin
      n_fail++;
      $display("FAIL %s: en=%0b wr=%0b addr=%h din=%h faddr=%h we=%0b%0b tag=%0b%0b busy=%0b%0b ack=%0b, required all 0",
               name, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.fill_addr,
               bus.i_data_we, bus.d_data_we, bus.i_tag_we, bus.d_tag_we,
               bus.i_busy, bus.d_busy, bus.wr_ack);
    end
  endtask

  // Main stimulus.
  initial begin
    int seen, late, m;
    logic [15:0] ra, rw, rd, ri, rr;
    for (int i = 0; i < 32768; i++) begin
      phys_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
      ref_mem[i]  = phys_mem[i];
    end
    bus.ifill_req = 1'b0; bus.dfill_req = 1'b0; bus.wr_req = 1'b0;
    bus.ifill_addr = '0; bus.dfill_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    sb_en = 1'b1;

    // I fill of a misaligned address.
    run_ops(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h1234);
    // D and I contention.
    run_ops(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 16'h0, 16'h2000);
    // Write-miss: fill first, then write, then read the line back.
    run_ops(1'b1, 1'b1, 1'b0, 16'h0046, 16'h0046, 16'hBEEF, 16'h0);
    run_ops(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0, 16'h0);
    // Write then I fill of the written line.
    run_ops(1'b0, 1'b1, 1'b1, 16'h0, 16'h0100, 16'h1234, 16'h0100);

    // Spurious valid while idle.
    @(posedge clk);
    #1 inject_valid = 1'b1; inject_data = 16'hDEAD;
    @(negedge clk);
    check_all_zero("spurious_valid");
    @(posedge clk);
    #1 inject_valid = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_spurious");
    run_ops(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h3008);

    // Reset after three returns of an I fill.
    @(posedge clk);
    #1 sb_en = 1'b0;
    bus.ifill_addr = 16'h1234; bus.ifill_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 60 && seen < 3; k++) begin
      @(negedge clk);
      if (bus.i_data_we) seen++;
    end
    n_checks++;
    if (seen < 3) begin
      n_fail++;
      $display("FAIL rst_setup: saw %0d returns, required 3", seen);
    end
    rst = 1'b1; bus.ifill_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_midfill_reset");
    late = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.mem_data_valid) late++;
      n_checks++;
      if (bus.i_data_we || bus.d_data_we || bus.i_tag_we || bus.d_tag_we || bus.mem_en) begin
        n_fail++;
        $display("FAIL late_valid: we=%0b%0b tag=%0b%0b en=%0b, required all 0",
                 bus.i_data_we, bus.d_data_we, bus.i_tag_we, bus.d_tag_we, bus.mem_en);
      end
      @(negedge clk);
    end
    n_checks++;
    if (late == 0) begin
      n_fail++;
      $display("FAIL late_valid_count: got %0d late returns, required > 0", late);
    end
    cmd_q.delete(); fill_q.delete();
    sb_en = 1'b1;
    run_ops(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h1234);

    // Randomized request mixes.
    for (int it = 0; it < 25; it++) begin
      m  = $urandom_range(1, 7);
      ra = 16'($urandom);
      ri = 16'($urandom);
      rd = 16'($urandom);
      rr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rw = {ra[15:4], rr[3:1], 1'b0};
      else                           rw = {rr[15:1], 1'b0};
      run_ops(m[0], m[1], m[2], ra, rw, rd, ri);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
